alu_issue_stage: RTL and testbench
==================================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 2, giving the operand-queue entry count (power of two, >= 2).
REQ-003 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1, a synchronous active-high reset sampled on the rising edge of clk.
REQ-005 The module SHALL have port in_valid, input, 1, meaning an upstream op is offered.
REQ-006 The module SHALL have port in_ready, output, 1, meaning a queue slot is free.
REQ-007 The module SHALL have port in_op, input, 3: bits [1:0] select AND/OR/XOR/NOR (00/01/10/11); bit 2 inverts operand b.
REQ-008 The module SHALL have port in_a, input, WIDTH, operand a.
REQ-009 The module SHALL have port in_b, input, WIDTH, operand b.
REQ-010 The module SHALL have port in_use_prev, input, 1, which substitutes the last logic result for operand a.
REQ-011 The module SHALL have port res_valid, input, 1, meaning a downstream logic result is present.
REQ-012 The module SHALL have port res_data, input, WIDTH, the downstream logic result.
REQ-013 The module SHALL have port out_valid, output, 1, meaning the queue head is valid.
REQ-014 The module SHALL have port out_ready, input, 1, meaning the logic unit accepts the head.
REQ-015 The module SHALL have port out_a, output, WIDTH, the effective operand a.
REQ-016 The module SHALL have port out_b, output, WIDTH, the effective operand b.
REQ-017 The module SHALL have port out_logic_sel, output, 2, the logic-unit operation select.
REQ-018 The module SHALL have port issue_count, output, 16, counting ops issued since reset.

Function
REQ-019 An accept SHALL occur on any edge where in_valid and in_ready are both 1; a pop SHALL occur on any edge where out_valid and out_ready are both 1.
REQ-020 in_ready SHALL be 1 exactly when queue occupancy < DEPTH, combinationally from occupancy only.
REQ-021 in_ready SHALL NOT depend on out_ready; with a full queue and a pop in the same cycle, a push SHALL NOT be accepted.
REQ-022 On accept, the entry SHALL store a_eff = in_use_prev ? prev : in_a, b_eff = in_op[2] ? ~in_b : in_b, and sel = in_op[1:0].
REQ-023 The prev register SHALL load res_data on every edge where res_valid is 1.
REQ-024 If an accept with in_use_prev = 1 coincides with res_valid = 1, a_eff SHALL be res_data (same-cycle bypass), not the old prev value.
REQ-025 out_valid SHALL be 1 exactly when occupancy > 0.
REQ-026 out_a, out_b and out_logic_sel SHALL present the head entry from registers, and SHALL be all-zero when out_valid = 0.
REQ-027 Latency from accept into an empty queue to out_valid = 1 SHALL be exactly one cycle; there SHALL be no combinational in-to-out path.
REQ-028 Simultaneous accept and pop with 0 < occupancy < DEPTH SHALL leave occupancy unchanged and preserve FIFO order.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH.
REQ-030 issue_count SHALL increment by 1 on each pop and wrap from 16'hFFFF to 0.
REQ-031 Outputs SHALL hold stable while out_valid = 1 and out_ready = 0.

Reset
REQ-032 While rst = 1, occupancy, both pointers, prev and issue_count SHALL clear to 0, giving out_valid = 0, in_ready = 1 and all-zero outputs on the next edge.
REQ-033 rst SHALL override a simultaneous accept, pop or res_valid; queued entries present mid-operation SHALL be discarded.

Verification
REQ-034 From reset, accept op=001, a=F0F0F0F0, b=0F0F0F0F with out_ready=1 -> the next cycle gives out_valid=1, out_a=F0F0F0F0, out_b=0F0F0F0F, sel=01, and after the pop issue_count=1.
REQ-035 Accept op=110, b=00000000 -> out_b=FFFFFFFF and sel=10.
REQ-036 Hold out_ready=0 and offer 3 ops with DEPTH=2 -> in_ready=0 after 2 accepts; the third is accepted only after a pop, and pop order is 1,2,3.
REQ-037 Drive res_valid=1 with res_data=12345678 in the same cycle as an accept with in_use_prev=1 -> out_a=12345678; a later accept with in_use_prev=1 and no res_valid -> out_a=12345678.
REQ-038 Assert rst with 2 entries queued and issue_count=5 -> the next cycle gives out_valid=0, in_ready=1, issue_count=0, all outputs 0.
REQ-039 Preload issue_count to FFFF via 65535 pops, then pop once -> issue_count=0.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Issue stage for the logic unit: queues operand/op-select entries with
// a last-result bypass for operand a and a count of ops issued.
module alu_issue_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_use_prev,
  input  logic             res_valid,
  input  logic [WIDTH-1:0] res_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [1:0]       out_logic_sel,
  output logic [15:0]      issue_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       sel;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           wr_entry;
  entry_t           head;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] prev;
  logic             accept;
  logic             pop;

  // Ready looks only at occupancy, so a full queue never accepts on a pop cycle.
  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // A result arriving this cycle wins over the stored prev value.
  always_comb begin
    wr_entry     = '0;
    wr_entry.a   = in_use_prev ? (res_valid ? res_data : prev) : in_a;
    wr_entry.b   = in_op[2] ? ~in_b : in_b;
    wr_entry.sel = in_op[1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      prev        <= '0;
      issue_count <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr      <= rd_ptr + AW'(1);
        issue_count <= issue_count + 16'd1;
      end
      if (accept && !pop) begin
        count <= count + CW'(1);
      end else if (!accept && pop) begin
        count <= count - CW'(1);
      end
      if (res_valid) begin
        prev <= res_data;
      end
    end
  end

  // Head is forced to zero while the queue is empty.
  always_comb begin
    head = '0;
    if (out_valid) begin
      head = mem[rd_ptr];
    end
  end

  assign out_a         = head.a;
  assign out_b         = head.b;
  assign out_logic_sel = head.sel;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: table vectors plus hand sequences,
// with a queue of expected entries compared as the DUT presents them.
module tb_alu_issue_stage;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 2;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  sel;
  } entry_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        use_prev;
    logic        rv;
    logic [31:0] rd;
    entry_t      exp;
  } vec_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_use_prev;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic [1:0]       out_logic_sel;
  logic [15:0]      issue_count;

  alu_issue_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_use_prev(in_use_prev),
    .res_valid(res_valid), .res_data(res_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_logic_sel(out_logic_sel),
    .issue_count(issue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  entry_t      sb[$];
  logic [15:0] exp_cnt;
  int          total;
  int          bad;
  bit          chk;
  vec_t        vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: compare current outputs to the model, drive, clock, update model.
  task automatic tick(input logic v, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic up, input logic rv,
                      input logic [31:0] rd, input logic ordy, input entry_t exp);
    bit acc;
    bit pp;
    if (chk) begin
      check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      check("in_ready", 32'(in_ready), 32'(sb.size() < DEPTH));
      check("issue_count", 32'(issue_count), 32'(exp_cnt));
      if (sb.size() != 0) begin
        check("out_a", out_a, sb[0].a);
        check("out_b", out_b, sb[0].b);
        check("out_sel", 32'(out_logic_sel), 32'(sb[0].sel));
      end else begin
        check("idle_a", out_a, 32'h0);
        check("idle_b", out_b, 32'h0);
        check("idle_sel", 32'(out_logic_sel), 32'h0);
      end
    end
    in_valid = v; in_op = op; in_a = a; in_b = b; in_use_prev = up;
    res_valid = rv; res_data = rd; out_ready = ordy;
    acc = v && (sb.size() < DEPTH);
    pp  = ordy && (sb.size() != 0);
    @(posedge clk);
    #1;
    if (pp) begin
      void'(sb.pop_front());
      exp_cnt = exp_cnt + 16'd1;
    end
    if (acc) sb.push_back(exp);
  endtask

  task automatic idle(input logic ordy);
    tick(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, ordy, '0);
  endtask

  task automatic do_reset(input logic v, input logic ordy, input logic rv);
    rst = 1'b1;
    in_valid = v; in_op = 3'b001; in_a = 32'h1111_1111; in_b = 32'h2222_2222;
    in_use_prev = 1'b0; res_valid = rv; res_data = 32'hFFFF_FFFF; out_ready = ordy;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    exp_cnt = 16'h0;
  endtask

  initial begin
    total = 0; bad = 0; chk = 1'b0; exp_cnt = 16'h0;
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
    in_use_prev = 1'b0; res_valid = 1'b0; res_data = '0; out_ready = 1'b0;

    vecs[0] = '{3'b001, 32'hF0F0F0F0, 32'h0F0F0F0F, 1'b0, 1'b0, 32'h0, '{32'hF0F0F0F0, 32'h0F0F0F0F, 2'b01}};
    vecs[1] = '{3'b110, 32'h13579BDF, 32'h00000000, 1'b0, 1'b0, 32'h0, '{32'h13579BDF, 32'hFFFFFFFF, 2'b10}};
    vecs[2] = '{3'b000, 32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b0, 32'h0, '{32'hAAAAAAAA, 32'h55555555, 2'b00}};
    vecs[3] = '{3'b111, 32'h00000000, 32'hFFFF0000, 1'b0, 1'b0, 32'h0, '{32'h00000000, 32'h0000FFFF, 2'b11}};
    vecs[4] = '{3'b101, 32'h00000001, 32'h00000002, 1'b0, 1'b1, 32'hDEADBEEF, '{32'h00000001, 32'hFFFFFFFD, 2'b01}};
    vecs[5] = '{3'b010, 32'h00000003, 32'h00000004, 1'b1, 1'b0, 32'h0, '{32'hDEADBEEF, 32'h00000004, 2'b10}};
    vecs[6] = '{3'b011, 32'h00000005, 32'h00000006, 1'b1, 1'b1, 32'hCAFEF00D, '{32'hCAFEF00D, 32'h00000006, 2'b11}};

    do_reset(1'b0, 1'b0, 1'b0);
    chk = 1'b1;
    idle(1'b0);

    // Table vectors: accept each while the previous one pops.
    foreach (vecs[i])
      tick(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].use_prev, vecs[i].rv,
           vecs[i].rd, 1'b1, vecs[i].exp);
    idle(1'b1);
    idle(1'b1);

    // Backpressure: two fill the queue, third waits until after a pop.
    tick(1'b1, 3'b000, 32'h11, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, '{32'h11, 32'h0, 2'b00});
    tick(1'b1, 3'b001, 32'h22, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, '{32'h22, 32'h0, 2'b01});
    tick(1'b1, 3'b010, 32'h33, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, '{32'h33, 32'h0, 2'b10});
    tick(1'b1, 3'b010, 32'h33, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, '{32'h33, 32'h0, 2'b10});
    tick(1'b1, 3'b010, 32'h33, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, '{32'h33, 32'h0, 2'b10});
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Same-cycle result bypass, then reuse of the stored result.
    tick(1'b1, 3'b000, 32'h0BAD0BAD, 32'h1, 1'b1, 1'b1, 32'h12345678, 1'b1, '{32'h12345678, 32'h1, 2'b00});
    tick(1'b1, 3'b001, 32'h0BAD0BAD, 32'h2, 1'b1, 1'b0, 32'h0, 1'b1, '{32'h12345678, 32'h2, 2'b01});
    idle(1'b1);
    idle(1'b1);

    // Reset mid-operation with two queued and issue_count at 5.
    do_reset(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      tick(1'b1, 3'b011, 32'(i), 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0, 1'b1, '{32'(i), 32'hA5A5A5A5, 2'b11});
    idle(1'b1);
    tick(1'b1, 3'b000, 32'h77, 32'h88, 1'b0, 1'b0, 32'h0, 1'b0, '{32'h77, 32'h88, 2'b00});
    tick(1'b1, 3'b000, 32'h99, 32'hAA, 1'b0, 1'b0, 32'h0, 1'b0, '{32'h99, 32'hAA, 2'b00});
    check("pre_reset_count", 32'(issue_count), 32'd5);
    do_reset(1'b1, 1'b1, 1'b1);
    idle(1'b0);
    tick(1'b1, 3'b000, 32'hFFFFFFFF, 32'h5, 1'b1, 1'b0, 32'h0, 1'b1, '{32'h0, 32'h5, 2'b00});
    idle(1'b1);
    idle(1'b0);

    // issue_count wrap after 65535 pops.
    do_reset(1'b0, 1'b0, 1'b0);
    chk = 1'b0;
    for (int i = 0; i < 70000 && exp_cnt != 16'hFFFF; i++)
      tick(1'b1, 3'b001, 32'h1, 32'h2, 1'b0, 1'b0, 32'h0, 1'b1, '{32'h1, 32'h2, 2'b01});
    chk = 1'b1;
    idle(1'b1);
    idle(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
